// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch front end
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DROP = 2'd2;
    localparam state_t ST_HALT = 2'd3;

    localparam logic [3:0] HLT_OPCODE = 4'hF;
    localparam int         PC_INC     = 2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - PC-tagged instruction buffer between fetch and decode
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    // An empty buffer presents zeros so stale entries never leak to decode.
    assign rdata_o = valid_o ? mem_q[head_q] : '0;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    // Pointer and occupancy next state; clear wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array; needs no reset because reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with flush, redirect and halt
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               hlt
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic                issue;
    logic                push;
    logic                fifo_full;
    logic [ADDR_W+INSTR_W-1:0] head;
    logic [3:0]          resp_opcode;

    assign resp_opcode = imem_data[INSTR_W-1 -: 4];
    assign imem_addr   = fetch_pc_q;
    // Kept apart from issue so the reset pin never feeds register data paths.
    assign imem_req    = issue & rst_n;

    // FSM and fetch PC next state; a redirect overrides the per-state decision.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!redirect && !fifo_full) begin
                    issue      = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    push    = ~redirect;
                    state_d = (resp_opcode == HLT_OPCODE) ? ST_HALT : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_valid) state_d = ST_IDLE;
            end
            default: state_d = state_q;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // A response landing in the redirect cycle retires the request itself.
            if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_valid)
                state_d = ST_DROP;
            else
                state_d = ST_IDLE;
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // fetch_pc has already advanced past the outstanding request, so step back to tag it.
    fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (redirect),
        .push_i  (push),
        .wdata_i ({fetch_pc_q - ADDR_W'(PC_INC), imem_data}),
        .pop_i   (instr_ready),
        .rdata_o (head),
        .valid_o (instr_valid),
        .full_o  (fifo_full)
    );

    assign {pc, instr} = head;
    assign hlt         = instr_valid & (instr[INSTR_W-1 -: 4] == HLT_OPCODE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        hlt;

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .hlt         (hlt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          outstanding = 0;
    bit          flushed = 0;
    bit          halted = 0;
    logic [15:0] next_pc = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] hlt_addr = 16'hFFFF;
    int          resp_cycle = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_q[$];
    bit          stray = 0;
    logic [15:0] stray_data = '0;
    int          req_count = 0;
    logic [15:0] req_log[$];
    bit          last_req = 0;
    logic [15:0] last_addr = '0;
    bit          obs_valid = 0;
    bit          obs_hlt = 0;
    logic [15:0] obs_pc = '0;

    function automatic logic [15:0] word(input logic [15:0] a);
        if (a == hlt_addr) return 16'hF000;
        return {4'h1, a[11:0] ^ 12'h123};
    endfunction

    // One clock cycle: drive at negedge, check against model, advance model, wait next negedge.
    task automatic tick(input bit rdy, input bit redir, input logic [15:0] rpc);
        bit          resp, exp_req, exp_valid;
        logic [31:0] head;
        logic [15:0] w;
        resp        = outstanding && (cyc == resp_cycle);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_valid  = resp || stray;
        imem_data   = resp ? word(req_addr) : (stray ? stray_data : 16'h0);
        #1;
        exp_req = !outstanding && !halted && (exp_q.size() < 4) && !redir;
        n_checks++;
        if (imem_req !== exp_req) begin
            n_err++;
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            n_checks++;
            if (imem_addr !== next_pc) begin
                n_err++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, next_pc);
            end
        end
        exp_valid = (exp_q.size() != 0);
        n_checks++;
        if (instr_valid !== exp_valid) begin
            n_err++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_valid);
        end
        if (exp_valid) begin
            head = exp_q[0];
            n_checks++;
            if ({pc, instr} !== head) begin
                n_err++;
                $display("FAIL head cyc=%0d got=%h exp=%h", cyc, {pc, instr}, head);
            end
            n_checks++;
            if (hlt !== (head[15:12] == 4'hF)) begin
                n_err++;
                $display("FAIL hlt cyc=%0d got=%b exp=%b", cyc, hlt, head[15:12] == 4'hF);
            end
        end else begin
            n_checks++;
            if (hlt !== 1'b0) begin
                n_err++;
                $display("FAIL hlt_empty cyc=%0d got=%b exp=0", cyc, hlt);
            end
        end
        last_req  = (imem_req === 1'b1);
        last_addr = imem_addr;
        obs_valid = (instr_valid === 1'b1);
        obs_hlt   = (hlt === 1'b1);
        obs_pc    = pc;
        if (last_req) begin
            req_count++;
            req_log.push_back(imem_addr);
        end
        if (redir) begin
            exp_q.delete();
            next_pc = rpc;
            halted  = 0;
            if (outstanding) begin
                if (resp) begin
                    outstanding = 0;
                    flushed     = 0;
                end else begin
                    flushed = 1;
                end
            end
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (resp) begin
                outstanding = 0;
                if (!flushed) begin
                    w = word(req_addr);
                    exp_q.push_back({req_addr, w});
                    if (w[15:12] == 4'hF) halted = 1;
                end
                flushed = 0;
            end
            if (exp_req) begin
                outstanding = 1;
                req_addr    = next_pc;
                next_pc     = next_pc + 16'd2;
                resp_cycle  = cyc + int'($urandom_range(lat_max, lat_min));
            end
        end
        stray = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check outputs clear at once, release one cycle later.
    task automatic do_reset();
        rst_n       = 1'b0;
        imem_valid  = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_instr_valid got=%b exp=0", instr_valid);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_imem_req got=%b exp=0", imem_req);
        end
        n_checks++;
        if ({hlt, pc, instr} !== 33'h0) begin
            n_err++;
            $display("FAIL reset_head got=%h exp=0", {hlt, pc, instr});
        end
        exp_q.delete();
        outstanding = 0;
        flushed     = 0;
        halted      = 0;
        next_pc     = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        cyc       = 0;
        req_count = 0;
        req_log.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        hlt_addr = 16'hFFFF;
        tick(1, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0000)) begin
            n_err++;
            $display("FAIL first_req got=%b/%h exp=1/0000", last_req, last_addr);
        end
    endtask

    task automatic test_stream();
        int first_valid = -1;
        logic [15:0] first_pc = '1;
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 16'h0);
            if (obs_valid && first_valid < 0) begin
                first_valid = cyc - 1;
                first_pc    = obs_pc;
            end
        end
        n_checks++;
        if (first_valid != 2 || first_pc !== 16'h0000) begin
            n_err++;
            $display("FAIL stream_first got=%0d/%h exp=2/0000", first_valid, first_pc);
        end
        n_checks++;
        if (req_count != 5 || req_log[1] !== 16'h0002) begin
            n_err++;
            $display("FAIL stream_reqs got=%0d exp=5", req_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 14; i++) tick(0, 0, 16'h0);
        n_checks++;
        if (req_count != 4 || req_log[3] !== 16'h0006) begin
            n_err++;
            $display("FAIL stall_reqs got=%0d exp=4", req_count);
        end
        tick(1, 0, 16'h0);
        tick(0, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0008)) begin
            n_err++;
            $display("FAIL stall_resume got=%b/%h exp=1/0008", last_req, last_addr);
        end
    endtask

    task automatic test_redirect();
        bit seen4 = 0;
        do_reset();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 7; i++) tick(0, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0004)) begin
            n_err++;
            $display("FAIL redir_setup got=%b/%h exp=1/0004", last_req, last_addr);
        end
        tick(0, 1, 16'h0040);
        tick(0, 0, 16'h0);
        n_checks++;
        if (obs_valid || last_req) begin
            n_err++;
            $display("FAIL redir_drop got=%b/%b exp=0/0", obs_valid, last_req);
        end
        tick(1, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0040)) begin
            n_err++;
            $display("FAIL redir_target got=%b/%h exp=1/0040", last_req, last_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 16'h0);
            if (obs_valid && obs_pc == 16'h0004) seen4 = 1;
        end
        n_checks++;
        if (seen4) begin
            n_err++;
            $display("FAIL redir_stale got=seen exp=absent");
        end
    endtask

    task automatic test_halt();
        bit saw = 0;
        do_reset();
        lat_min = 1; lat_max = 1;
        hlt_addr = 16'h0006;
        for (int i = 0; i < 9; i++) tick(0, 0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 16'h0);
            if (obs_hlt && obs_pc == 16'h0006) saw = 1;
        end
        n_checks++;
        if (req_count != 4) begin
            n_err++;
            $display("FAIL halt_reqs got=%0d exp=4", req_count);
        end
        n_checks++;
        if (!saw) begin
            n_err++;
            $display("FAIL halt_head got=unseen exp=hlt at pc 0006");
        end
        hlt_addr = 16'hFFFF;
        tick(1, 1, 16'h0000);
        tick(1, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0000)) begin
            n_err++;
            $display("FAIL halt_resume got=%b/%h exp=1/0000", last_req, last_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 1;
        tick(1, 1, 16'hFFFC);
        for (int i = 0; i < 6; i++) tick(1, 0, 16'h0);
        n_checks++;
        if (req_log.size() < 3 || req_log[1] !== 16'hFFFE || req_log[2] !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap got=%0d reqs exp=FFFC,FFFE,0000", req_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit saw_hlt = 0;
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 7; i++) tick(0, 0, 16'h0);
        n_checks++;
        if (!(obs_valid && outstanding && exp_q.size() == 3)) begin
            n_err++;
            $display("FAIL mid_setup got=%b/%0d exp=1/3", obs_valid, exp_q.size());
        end
        do_reset();
        stray      = 1;
        stray_data = 16'hF000;
        tick(1, 0, 16'h0);
        n_checks++;
        if (!(last_req && last_addr == 16'h0000)) begin
            n_err++;
            $display("FAIL mid_restart got=%b/%h exp=1/0000", last_req, last_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 16'h0);
            if (obs_hlt) saw_hlt = 1;
        end
        n_checks++;
        if (saw_hlt) begin
            n_err++;
            $display("FAIL mid_stale got=hlt exp=no hlt");
        end
    endtask

    task automatic test_random();
        bit          rdy, redir;
        logic [15:0] rpc;
        do_reset();
        lat_min = 1; lat_max = 3;
        hlt_addr = 16'h0010;
        for (int i = 0; i < 800; i++) begin
            rdy   = ($urandom_range(3, 0) != 0);
            redir = ($urandom_range(24, 0) == 0) || (halted && $urandom_range(4, 0) == 0);
            rpc   = 16'($urandom_range(31, 0) * 2);
            if (redir && $urandom_range(1, 0) == 0) hlt_addr = 16'($urandom_range(31, 0) * 2);
            tick(rdy, redir, rpc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
